// File: rtl/alu_share_sched.sv
// -----------------------------------------------------------------------------
// alu_share_sched
//
// Round-robin scheduler sharing one N-bit add/multiply unit between two
// requesters. One operation is in flight at a time: add completes in a single
// EXEC cycle, multiply runs N shift-add steps on the shared adder. The result
// is held in DONE until the consumer takes it.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   reqK_valid / reqK_ready   request handshake for requester K (K = 0, 1)
//   reqK_op                   0 = add with carry-in, 1 = unsigned multiply
//   reqK_x, reqK_y            N-bit unsigned operands
//   reqK_cin                  carry-in (add only)
//   res_valid / res_ready     result handshake
//   res_id                    requester that issued the result
//   res_data                  2N-bit result ({0, cout, sum} or product)
//   busy                      high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module alu_share_sched #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req0_op,
    input  logic [N-1:0]   req0_x,
    input  logic [N-1:0]   req0_y,
    input  logic           req0_cin,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic           req1_op,
    input  logic [N-1:0]   req1_x,
    input  logic [N-1:0]   req1_y,
    input  logic           req1_cin,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_id,
    output logic [2*N-1:0] res_data,
    output logic           busy
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic           last_grant;
    logic           op_q;
    logic [N-1:0]   x_q;
    logic [N-1:0]   y_q;
    logic           cin_q;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  count;

    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [2*N-1:0] partial;
    logic [2*N-1:0] acc_next;
    logic [N:0]     sum;

    // Round-robin: on contention the requester that did not win last time
    // is granted; a lone requester is always granted.
    // NOTE: every signal assigned in always_comb gets a value on every path,
    // so no latch is inferred.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign res_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    // One shift-add step: add x shifted by the current bit position when
    // that multiplier bit is set. 2N bits never overflow for an NxN product.
    assign partial  = y_q[count] ? ({{N{1'b0}}, x_q} << count) : '0;
    assign acc_next = acc + partial;
    assign sum      = {1'b0, x_q} + {1'b0, y_q} + {{N{1'b0}}, cin_q};

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cin_q      <= 1'b0;
            acc        <= '0;
            count      <= '0;
            res_id     <= 1'b0;
            res_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Grants are exclusive, so req1_ready alone picks
                        // which requester's operands are captured.
                        op_q       <= req1_ready ? req1_op  : req0_op;
                        x_q        <= req1_ready ? req1_x   : req0_x;
                        y_q        <= req1_ready ? req1_y   : req0_y;
                        cin_q      <= req1_ready ? req1_cin : req0_cin;
                        res_id     <= req1_ready;
                        last_grant <= req1_ready;
                        acc        <= '0;
                        count      <= '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (!op_q) begin
                        res_data <= {{(N-1){1'b0}}, sum};
                        state    <= DONE;
                    end else begin
                        acc <= acc_next;
                        if (count == LAST) begin
                            res_data <= acc_next;
                            state    <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
